// File: rtl/dotp_accumulator_if.sv
// Result channel of the dot-product accumulator: saturated sum plus status flags
// Carries the valid/ready handshake towards the writeback/STORE_RESULT path.
// master: accumulator (drives result/flags/valid); slave: consumer (drives ready).
interface dotp_accumulator_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] result;       // saturated signed dot product
  logic                  result_valid; // result/flags are presented
  logic                  result_ready; // consumer accepts this cycle
  logic                  overflow;     // result was clamped
  logic                  truncated;    // sequence cut short by STOP

  modport master (
    output result,
    output result_valid,
    output overflow,
    output truncated,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_valid,
    input  overflow,
    input  truncated,
    output result_ready
  );
endinterface

// File: rtl/dotp_accumulator.sv
// Sums vec_len signed ALU products (opcode DOTP, re-timed by one cycle) into a wide acc; emits one saturated result.
// Latency: result_valid rises the cycle after the last product is seen (IDLE->IDLE in vec_len+2 cycles).
// Backpressure: result held in HOLD until result_ready; products arriving in HOLD are dropped, start ignored.
// Ports: clk/rstn (sync active-low), opcode_in (ALU opcode stream), alu_out (ALU lane output),
//        start/vec_len (arm a new sum), busy (ACCUM or HOLD), res_if (result handshake, master side).
module dotp_accumulator #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 4,
  parameter int ACC_WIDTH    = 40,  // keep >= DATA_WIDTH + LEN_WIDTH so the sum itself never wraps
  parameter int LEN_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [OPCODE_WIDTH-1:0] opcode_in,
  input  logic [DATA_WIDTH-1:0]   alu_out,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    vec_len,
  output logic                    busy,
  dotp_accumulator_if.master      res_if
);

  localparam logic [OPCODE_WIDTH-1:0] OP_DOTP = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_STOP = OPCODE_WIDTH'(8);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // Signed DATA_WIDTH bounds expressed at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                   r_state;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic [LEN_WIDTH-1:0]         r_count;
  logic [OPCODE_WIDTH-1:0]      r_opcode_d;
  logic [DATA_WIDTH-1:0]        r_result;
  logic                         r_overflow;
  logic                         r_truncated;

  logic                         w_event;
  logic signed [ACC_WIDTH-1:0]  w_product;
  logic signed [ACC_WIDTH-1:0]  w_sum;
  logic signed [ACC_WIDTH-1:0]  w_sat_src;
  logic [DATA_WIDTH-1:0]        w_sat;
  logic                         w_ovf;

  // alu_out belongs to the opcode issued one cycle earlier, hence r_opcode_d.
  assign w_event   = (r_state == S_ACCUM) && (r_opcode_d == OP_DOTP);
  assign w_product = {{(ACC_WIDTH-DATA_WIDTH){alu_out[DATA_WIDTH-1]}}, alu_out};
  assign w_sum     = r_acc + w_product;

  // One saturator serves both exits: final product (sum) or STOP (current acc).
  always_comb begin
    w_sat_src = w_event ? w_sum : r_acc;
    w_sat     = w_sat_src[DATA_WIDTH-1:0];
    w_ovf     = 1'b0;
    if (w_sat_src > SAT_MAX) begin
      w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      w_ovf = 1'b1;
    end else if (w_sat_src < SAT_MIN) begin
      w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_opcode_d  <= '0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_truncated <= 1'b0;
    end else begin
      r_opcode_d <= opcode_in;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_truncated <= 1'b0;
            if (vec_len != '0) begin
              r_acc   <= '0;
              r_count <= vec_len;
              r_state <= S_ACCUM;
            end else begin
              r_result   <= '0;
              r_overflow <= 1'b0;
              r_state    <= S_HOLD;
            end
          end
        end
        S_ACCUM: begin
          if (w_event) begin
            r_acc   <= w_sum;
            r_count <= r_count - LEN_WIDTH'(1);
            if (r_count == LEN_WIDTH'(1)) begin
              r_result   <= w_sat;
              r_overflow <= w_ovf;
              r_state    <= S_HOLD;
            end
          end else if (r_opcode_d == OP_STOP) begin
            r_result    <= w_sat;
            r_overflow  <= w_ovf;
            r_truncated <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (res_if.result_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy                = (r_state != S_IDLE);
  assign res_if.result_valid = (r_state == S_HOLD);
  assign res_if.result       = r_result;
  assign res_if.overflow     = r_overflow;
  assign res_if.truncated    = r_truncated;

endmodule

// File: doc/dotp_accumulator.md
Name: dotp_accumulator

Overview:
- Downstream stage of the SIMD ALU lane. Consumes the lane's registered 32-bit output during DOTP sequences and sums N signed 16x16 products into a wide accumulator.
- Presents one saturated 32-bit dot-product result to the writeback/STORE_RESULT path over a valid/ready handshake.
- Snoops the same opcode stream that drives the ALU and re-times it internally to match the ALU's 1-cycle latency.

Parameters:
- DATA_WIDTH, 32, width of the ALU output and the result.
- OPCODE_WIDTH, 4, opcode width; encoding NOOP=0, ADD=1, SUB=2, MUL=3, DOTP=4, STORE_TEMP_S1=5, STORE_TEMP_S2=6, STORE_RESULT=7, STOP=8.
- ACC_WIDTH, 40, internal accumulator width (must be >= DATA_WIDTH+8).
- LEN_WIDTH, 8, width of the vector-length input.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- opcode_in  in  OPCODE_WIDTH  same opcode presented to the ALU this cycle.
- alu_out  in  DATA_WIDTH  ALU lane output; signed product when the ALU's delayed opcode is DOTP.
- start  in  1  pulse: arm a new dot product.
- vec_len  in  LEN_WIDTH  number of products to sum; sampled on an accepted start.
- busy  out  1  high in ACCUM or HOLD.
- result  out  DATA_WIDTH  saturated signed sum.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- overflow  out  1  result was saturated; valid with result_valid.
- truncated  out  1  sequence ended by STOP before vec_len products; valid with result_valid.

Behaviour:
- Reset (rstn=0 at edge): state=IDLE. acc, count, opcode_d, result, result_valid, overflow and truncated are all 0. busy=0. Reset has priority over every other input, including mid-ACCUM or mid-HOLD; any partial sum is discarded.
- opcode_d: register of opcode_in, updated every cycle in every state. It aligns alu_out with the opcode that produced it (ALU latency = 1).
- Product event: state==ACCUM and opcode_d==DOTP. On each event, acc += sign_extend(alu_out to ACC_WIDTH) and count -= 1.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 and vec_len!=0: acc=0, count=vec_len, truncated=0, go to ACCUM.
  - start=1 and vec_len==0: go to HOLD with result=0, overflow=0, truncated=0.
  - A DOTP issued on opcode_in in the same cycle as start is counted, because its product arrives in the first ACCUM cycle.
- ACCUM:
  - Product event with count==1: compute final = acc + product. Register result = sat(final), overflow = (final outside the signed DATA_WIDTH range), then go to HOLD. result_valid is high the cycle after the last product is seen.
  - opcode_d==STOP (no product event possible that cycle): register result = sat(acc), truncated=1, go to HOLD.
  - Non-DOTP opcodes other than STOP: hold acc and count, remain in ACCUM. Gaps in the DOTP stream are allowed.
- HOLD:
  - result_valid=1. result, overflow and truncated are stable until the handshake completes.
  - result_valid & result_ready at an edge: go to IDLE; result_valid=0 next cycle. result keeps its last value.
  - DOTP products arriving in HOLD are ignored (not accumulated, not buffered).
- start outside IDLE is ignored; there is no restart and no queueing.
- sat(x): x > 2^(DATA_WIDTH-1)-1 gives 0x7FFFFFFF; x < -2^(DATA_WIDTH-1) gives 0x80000000; otherwise the low DATA_WIDTH bits.
- The accumulator itself never wraps for vec_len <= 2^LEN_WIDTH-1 given ACC_WIDTH >= DATA_WIDTH+LEN_WIDTH.
- busy = (state != IDLE). Throughput is one product per cycle. Minimum turnaround is IDLE to IDLE in vec_len+2 cycles with result_ready tied high.

Test Plan:
- Reset then start with vec_len=4 and back-to-back DOTP (first in the start cycle), alu_out = 3, -5, 7, 10 → result_valid rises 5 cycles after start, result=15, overflow=0, truncated=0; with result_ready=1 it falls the next cycle.
- vec_len=3 with DOTP/NOOP/ADD/DOTP/SUB/DOTP interleaved, products 100, 200, -50 (ADD/SUB outputs arbitrary) → result=250; non-DOTP cycles are not accumulated.
- vec_len=2 with alu_out = 0x7FFFFFFF twice → result=0x7FFFFFFF, overflow=1. Repeat with 0x80000000 twice → result=0x80000000, overflow=1.
- vec_len=5, two products 40 and 2, then STOP → result=42, truncated=1. A further DOTP with result_ready=0 for 3 cycles → result and flags stay stable; start pulses during HOLD are ignored.
- vec_len=0 start → result_valid the next cycle with result=0. Separately, rstn low for 1 cycle after 2 of 4 products → all outputs 0, state IDLE; a subsequent start with vec_len=1 and product 9 gives result=9 (no stale sum).
